// File: rtl/gpu_pkg.sv
// -----------------------------------------------------------------------------
// gpu_pkg
// Shared definitions for the plane compositor.
//   - Config register map (enable mask, background colour, per-layer keys)
//   - Reset values for the config and the {blank,hsync,vsync} delay taps
//   - R3G3B2 field positions and the RGB888 bit-replication expander
// -----------------------------------------------------------------------------
package gpu_pkg;

  // Config register map
  localparam logic [3:0] CFG_ENABLE   = 4'd0;
  localparam logic [3:0] CFG_BG       = 4'd1;
  localparam logic [3:0] CFG_KEY_BASE = 4'd2;

  // Reset config: every layer enabled, black background, black keyed out
  localparam logic       RST_ENABLE_BIT = 1'b1;
  localparam logic [7:0] RST_BG         = 8'h00;
  localparam logic [7:0] RST_KEY        = 8'h00;
  localparam logic       RST_KEYEN      = 1'b1;

  // Sync/blank bundle is packed {blank, hsync, vsync}; blank idles high
  localparam logic [2:0] SYNC_RST_VAL = 3'b100;

  // R3G3B2 field slices
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  // Expand R3G3B2 to RGB888 by repeating each field's MSBs into the low bits
  function automatic logic [23:0] expand_r3g3b2(input logic [7:0] px);
    logic [2:0] r3;
    logic [2:0] g3;
    logic [1:0] b2;
    r3 = px[R_MSB:R_LSB];
    g3 = px[G_MSB:G_LSB];
    b2 = px[B_MSB:B_LSB];
    return {r3, r3, r3[2:1], g3, g3, g3[2:1], b2, b2, b2, b2};
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// -----------------------------------------------------------------------------
// pipe_delay
// WIDTH-bit shift register of DEPTH stages used to align streams.
// DEPTH = 0 degenerates to a plain wire.
//   clk    : clock
//   rst_n  : asynchronous active-low reset; every stage loads RST_VAL
//   i_d    : data in
//   o_q    : data out, DEPTH cycles after i_d
// -----------------------------------------------------------------------------
module pipe_delay #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_wire
    // Clock and reset have no load in the pass-through case
    logic w_unused;
    assign w_unused = clk ^ rst_n;
    assign o_q      = i_d;
  end else begin : g_regs
    logic [DEPTH-1:0][WIDTH-1:0] r_stage;

    // NOTE: every tap is reset, not just the output, so blank reads as active
    // through the whole line until real timing has flushed it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_stage <= {DEPTH{RST_VAL}};
      end else begin
        // NOTE: non-blocking assignments make each stage take its neighbour's
        // old value, giving a true shift regardless of statement order.
        r_stage[0] <= i_d;
        for (int k = 1; k < DEPTH; k++) begin
          r_stage[k] <= r_stage[k-1];
        end
      end
    end

    assign o_q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/plane_compositor.sv
// -----------------------------------------------------------------------------
// plane_compositor
// N-layer R3G3B2 compositor with colour keys, enable mask and background.
// Layer 0 has the highest priority. Config writes land in a shadow copy that
// is committed to the active copy on each vsync_in rising edge.
//   clkPixel, resetn      : pixel clock, asynchronous active-low reset
//   layer_px              : one R3G3B2 pixel per layer, layer i at [8i+7:8i]
//   blank/hsync/vsync_in  : timing generator outputs
//   cfg_we/addr/wdata     : shadow config write port
//   r, g, b               : composited RGB888, zero while blanked
//   blank/hsync/vsync_out : timing delayed to match r/g/b
//   layer_hit             : winning layer index, NUM_LAYERS for background
//   frame_count           : number of config commits, wraps at 16 bits
// Latency: layer i -> rgb = 3 + LAYER_DELAY[i]; sync -> out = 3 + SYNC_DELAY.
// -----------------------------------------------------------------------------
module plane_compositor
  import gpu_pkg::*;
#(
  parameter int                            NUM_LAYERS  = 2,
  parameter int                            DELAY_W     = 3,
  parameter logic [NUM_LAYERS*DELAY_W-1:0] LAYER_DELAY = '0,
  parameter int                            SYNC_DELAY  = 0
) (
  input  logic                    clkPixel,
  input  logic                    resetn,
  input  logic [NUM_LAYERS*8-1:0] layer_px,
  input  logic                    blank_in,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    cfg_we,
  input  logic [3:0]              cfg_addr,
  input  logic [8:0]              cfg_wdata,
  output logic [7:0]              r,
  output logic [7:0]              g,
  output logic [7:0]              b,
  output logic                    blank_out,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic [3:0]              layer_hit,
  output logic [15:0]             frame_count
);

  localparam logic [3:0] HIT_BG = 4'(NUM_LAYERS);

  typedef struct packed {
    logic [NUM_LAYERS-1:0]      enable;
    logic [7:0]                 bg;
    logic [NUM_LAYERS-1:0]      keyen;
    logic [NUM_LAYERS-1:0][7:0] key;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    enable: {NUM_LAYERS{RST_ENABLE_BIT}},
    bg:     RST_BG,
    keyen:  {NUM_LAYERS{RST_KEYEN}},
    key:    {NUM_LAYERS{RST_KEY}}
  };

  // ---------------------------------------------------------------------------
  // Config: shadow with this cycle's write applied, committed on vsync rise
  // ---------------------------------------------------------------------------
  cfg_t        r_cfg_shadow;
  cfg_t        r_cfg_active;
  cfg_t        w_cfg_next;
  logic        r_vsync_prev;
  logic        w_commit;
  logic [15:0] r_frame_count;

  // NOTE: w_cfg_next gets a full default before any conditional update so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_cfg_next = r_cfg_shadow;
    if (cfg_we) begin
      if (cfg_addr == CFG_ENABLE) w_cfg_next.enable = cfg_wdata[NUM_LAYERS-1:0];
      if (cfg_addr == CFG_BG)     w_cfg_next.bg     = cfg_wdata[7:0];
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (cfg_addr == CFG_KEY_BASE + 4'(i)) begin
          w_cfg_next.key[i]   = cfg_wdata[7:0];
          w_cfg_next.keyen[i] = cfg_wdata[8];
        end
      end
    end
  end

  assign w_commit = vsync_in & ~r_vsync_prev;

  // Active loads w_cfg_next, so a write in the commit cycle is included
  always_ff @(posedge clkPixel or negedge resetn) begin
    if (!resetn) begin
      r_cfg_shadow  <= CFG_RST;
      r_cfg_active  <= CFG_RST;
      r_vsync_prev  <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_cfg_shadow <= w_cfg_next;
      r_vsync_prev <= vsync_in;
      if (w_commit) begin
        r_cfg_active  <= w_cfg_next;
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S0: per-layer and sync alignment delays
  // ---------------------------------------------------------------------------
  logic [NUM_LAYERS-1:0][7:0] w_dly_px;
  logic [2:0]                 w_dly_sync;

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer_dly
    pipe_delay #(
      .WIDTH   (8),
      .DEPTH   (int'(LAYER_DELAY[i*DELAY_W +: DELAY_W])),
      .RST_VAL (8'h00)
    ) u_dly (
      .clk   (clkPixel),
      .rst_n (resetn),
      .i_d   (layer_px[i*8 +: 8]),
      .o_q   (w_dly_px[i])
    );
  end

  pipe_delay #(
    .WIDTH   (3),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL (SYNC_RST_VAL)
  ) u_sync_dly (
    .clk   (clkPixel),
    .rst_n (resetn),
    .i_d   ({blank_in, hsync_in, vsync_in}),
    .o_q   (w_dly_sync)
  );

  // ---------------------------------------------------------------------------
  // S1 register, S2 priority select, S3 expand and blank
  // ---------------------------------------------------------------------------
  logic [NUM_LAYERS-1:0][7:0] r_s1_px;
  logic [2:0]                 r_s1_sync;
  logic [7:0]                 w_sel_color;
  logic [3:0]                 w_sel_hit;
  logic [7:0]                 r_s2_color;
  logic [3:0]                 r_s2_hit;
  logic [2:0]                 r_s2_sync;
  logic [23:0]                r_rgb;
  logic [3:0]                 r_hit;
  logic [2:0]                 r_sync_out;

  // Scan from lowest priority upward so the lowest visible index wins
  always_comb begin
    w_sel_color = r_cfg_active.bg;
    w_sel_hit   = HIT_BG;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (r_cfg_active.enable[i] &&
          !(r_cfg_active.keyen[i] && (r_s1_px[i] == r_cfg_active.key[i]))) begin
        w_sel_color = r_s1_px[i];
        w_sel_hit   = 4'(i);
      end
    end
  end

  always_ff @(posedge clkPixel or negedge resetn) begin
    if (!resetn) begin
      r_s1_px    <= '0;
      r_s1_sync  <= SYNC_RST_VAL;
      r_s2_color <= 8'h00;
      r_s2_hit   <= HIT_BG;
      r_s2_sync  <= SYNC_RST_VAL;
      r_rgb      <= 24'h0;
      r_hit      <= HIT_BG;
      r_sync_out <= SYNC_RST_VAL;
    end else begin
      r_s1_px    <= w_dly_px;
      r_s1_sync  <= w_dly_sync;
      r_s2_color <= w_sel_color;
      r_s2_hit   <= w_sel_hit;
      r_s2_sync  <= r_s1_sync;
      r_sync_out <= r_s2_sync;
      if (r_s2_sync[2]) begin
        r_rgb <= 24'h0;
        r_hit <= HIT_BG;
      end else begin
        r_rgb <= expand_r3g3b2(r_s2_color);
        r_hit <= r_s2_hit;
      end
    end
  end

  assign {r, g, b}                         = r_rgb;
  assign layer_hit                         = r_hit;
  assign {blank_out, hsync_out, vsync_out} = r_sync_out;
  assign frame_count                       = r_frame_count;

endmodule
